// File: rtl/cache_miss_controller.sv
// cache_miss_controller: control FSM for the 2-way, 8-index L1 cache.
// Resolves hits in zero cycles, picks a victim on a miss, writes back a
// dirty victim and fills the line over the pmem handshake. Owns one LRU
// bit per index (0 = way one is least recently used).
// Optional feature: define CACHE_PERF_CNT_EN to build saturating hit/miss
// counters; without it hit_count/miss_count are tied to zero.
module cache_miss_controller #(
    parameter int IDX_W    = 3,
    parameter int NUM_SETS = 2**IDX_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    input  logic [IDX_W-1:0] index,
    input  logic             hit,
    input  logic             set_one_hit,
    input  logic             set_two_hit,
    input  logic             set_one_valid,
    input  logic             set_two_valid,
    input  logic             set_one_dirty,
    input  logic             set_two_dirty,
    output logic             load_set_one,
    output logic             load_set_two,
    output logic             write_type_set_one,
    output logic             write_type_set_two,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    output logic [1:0]       pmem_addr_sel,
    output logic [15:0]      hit_count,
    output logic [15:0]      miss_count
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_e;

    state_e              state_q, state_d;
    logic [NUM_SETS-1:0] lru_q, lru_d;
    logic                victim_q, victim_d;   // 0 = way one, 1 = way two
    logic                req;
    logic                new_victim;
    logic                new_victim_dirty;

    assign req = mem_read | mem_write;

    // Victim for a miss in IDLE: an invalid way first, otherwise the LRU way
    always_comb begin
        if (!set_one_valid)      new_victim = 1'b0;
        else if (!set_two_valid) new_victim = 1'b1;
        else                     new_victim = lru_q[index];
    end

    assign new_victim_dirty = new_victim ? (set_two_valid & set_two_dirty)
                                         : (set_one_valid & set_one_dirty);

    // State, LRU and victim registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            lru_q    <= '0;
            victim_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lru_q    <= lru_d;
            victim_q <= victim_d;
        end
    end

    // Next state and Mealy outputs; everything held at 0 while reset_n is low
    always_comb begin
        state_d            = state_q;
        lru_d              = lru_q;
        victim_d           = victim_q;
        mem_resp           = 1'b0;
        load_set_one       = 1'b0;
        load_set_two       = 1'b0;
        write_type_set_one = 1'b0;
        write_type_set_two = 1'b0;
        pmem_read          = 1'b0;
        pmem_write         = 1'b0;
        pmem_addr_sel      = 2'd0;
        if (reset_n) begin
            unique case (state_q)
                IDLE: begin
                    if (req && hit) begin
                        mem_resp     = 1'b1;
                        // point the LRU bit at the way that did not hit
                        lru_d[index] = set_one_hit;
                        if (mem_write) begin
                            load_set_one       = set_one_hit;
                            write_type_set_one = set_one_hit;
                            load_set_two       = ~set_one_hit;
                            write_type_set_two = ~set_one_hit;
                        end
                    end else if (req) begin
                        victim_d = new_victim;
                        state_d  = new_victim_dirty ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = victim_q ? 2'd2 : 2'd1;
                    if (pmem_resp) state_d = FILL;
                end
                FILL: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        load_set_one = ~victim_q;
                        load_set_two = victim_q;
                        lru_d[index] = ~victim_q;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef CACHE_PERF_CNT_EN
    logic [15:0] hit_cnt_q, miss_cnt_q;
    logic        hit_evt, miss_evt;

    assign hit_evt  = (state_q == IDLE) & req & hit;
    assign miss_evt = (state_q == IDLE) & req & ~hit;

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_evt && hit_cnt_q != 16'hFFFF)   hit_cnt_q  <= hit_cnt_q + 16'd1;
            if (miss_evt && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cache_miss_controller.sv
// Bench for cache_miss_controller: a reference cache model (tags, valid,
// dirty, LRU per index) drives the datapath inputs and predicts every
// completion; a negedge monitor compares DUT outputs against the queue.
module tb_cache_miss_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_read, mem_write, mem_resp;
    logic [2:0]  index;
    logic        hit, set_one_hit, set_two_hit;
    logic        set_one_valid, set_two_valid, set_one_dirty, set_two_dirty;
    logic        load_set_one, load_set_two, write_type_set_one, write_type_set_two;
    logic        pmem_read, pmem_write, pmem_resp;
    logic [1:0]  pmem_addr_sel;
    logic [15:0] hit_count, miss_count;

    cache_miss_controller dut (
        .clk(clk), .reset_n(reset_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .index(index), .hit(hit), .set_one_hit(set_one_hit), .set_two_hit(set_two_hit),
        .set_one_valid(set_one_valid), .set_two_valid(set_two_valid),
        .set_one_dirty(set_one_dirty), .set_two_dirty(set_two_dirty),
        .load_set_one(load_set_one), .load_set_two(load_set_two),
        .write_type_set_one(write_type_set_one), .write_type_set_two(write_type_set_two),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .pmem_addr_sel(pmem_addr_sel), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // {mem_resp, load1, load2, wt1, wt2, pmem_read, pmem_write, addr_sel[1:0]}
    logic [8:0] outs;
    assign outs = {mem_resp, load_set_one, load_set_two, write_type_set_one,
                   write_type_set_two, pmem_read, pmem_write, pmem_addr_sel};

    // Reference model of the cache contents
    bit [1:0] mtag [8][2];
    bit       mvld [8][2];
    bit       mdty [8][2];
    bit       mlru [8];
    int       hits, misses;

    logic [8:0] expq [$];
    bit         mon_en = 1'b0;
    int         n_chk = 0;
    int         n_fail = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] mk(input bit r, input bit l1, input bit l2, input bit w1,
                                      input bit w2, input bit pr, input bit pw, input logic [1:0] s);
        return {r, l1, l2, w1, w2, pr, pw, s};
    endfunction

    // Monitor: pop on each completion, otherwise check held pmem requests / idle outputs
    always @(negedge clk) begin
        if (mon_en) begin
            if (expq.size() == 0)
                chk("idle_outs", {7'd0, outs}, 16'd0);
            else if (mem_resp || pmem_resp)
                chk("event", {7'd0, outs}, {7'd0, expq.pop_front()});
            else if (expq[0][3] || expq[0][2])
                chk("pmem_hold", {7'd0, outs}, {7'd0, expq[0] & 9'h00F});
            else
                chk("missing_resp", {7'd0, outs}, {7'd0, expq.pop_front()});
        end
    end

    task automatic drive_inputs(input int idx, input int tg, input bit rd, input bit wr);
        bit h1, h2;
        h1 = mvld[idx][0] && (mtag[idx][0] == tg);
        h2 = mvld[idx][1] && (mtag[idx][1] == tg);
        index         = idx[2:0];
        set_one_hit   = h1;
        set_two_hit   = h2;
        hit           = h1 | h2;
        set_one_valid = mvld[idx][0];
        set_two_valid = mvld[idx][1];
        set_one_dirty = mdty[idx][0];
        set_two_dirty = mdty[idx][1];
        mem_read      = rd;
        mem_write     = wr;
    endtask

    task automatic hit_resp(input int idx, input bit way, input bit wr);
        expq.push_back(mk(1'b1, wr && !way, wr && way, wr && !way, wr && way, 1'b0, 1'b0, 2'd0));
        mlru[idx] = !way;
        if (wr) mdty[idx][way] = 1'b1;
        hits++;
    endtask

    task automatic pmem_phase();
        repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
        pmem_resp = 1'b1;
        @(posedge clk); #1;
        pmem_resp = 1'b0;
    endtask

    // One CPU request; mode 0 = read, 1 = write, 2 = read+write (acts as write)
    task automatic do_req(input int idx, input int tg, input int mode, input bit abandon);
        bit rd, wr, h1, h2, v, wb;
        rd = (mode != 1);
        wr = (mode != 0);
        h1 = mvld[idx][0] && (mtag[idx][0] == tg);
        h2 = mvld[idx][1] && (mtag[idx][1] == tg);
        if (h1 || h2) begin
            hit_resp(idx, h2, wr);
            drive_inputs(idx, tg, rd, wr);
            @(posedge clk); #1;
            mem_read = 1'b0; mem_write = 1'b0;
        end else begin
            v  = !mvld[idx][0] ? 1'b0 : (!mvld[idx][1] ? 1'b1 : mlru[idx]);
            wb = mvld[idx][v] && mdty[idx][v];
            misses++;
            drive_inputs(idx, tg, rd, wr);
            @(posedge clk); #1;
            if (wb) expq.push_back(mk(0, 0, 0, 0, 0, 0, 1, v ? 2'd2 : 2'd1));
            expq.push_back(mk(0, !v, v, 0, 0, 1, 0, 2'd0));
            if (abandon) begin mem_read = 1'b0; mem_write = 1'b0; end
            if (wb) pmem_phase();
            pmem_phase();
            mtag[idx][v] = tg[1:0];
            mvld[idx][v] = 1'b1;
            mdty[idx][v] = 1'b0;
            mlru[idx]    = !v;
            if (!abandon) begin
                hit_resp(idx, v, wr);
                drive_inputs(idx, tg, rd, wr);
                @(posedge clk); #1;
                mem_read = 1'b0; mem_write = 1'b0;
            end else begin
                drive_inputs(idx, tg, 1'b0, 1'b0);
            end
        end
    endtask

    task automatic run_random(input int n);
        for (int i = 0; i < n; i++) begin
            do_req($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 2),
                   $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        end
    endtask

    function automatic logic [15:0] sat(input int n);
        return (n > 65535) ? 16'hFFFF : n[15:0];
    endfunction

    task automatic check_counters(input string nm);
`ifdef CACHE_PERF_CNT_EN
        chk({nm, "_hit_count"}, hit_count, sat(hits));
        chk({nm, "_miss_count"}, miss_count, sat(misses));
`else
        chk({nm, "_hit_count"}, hit_count, 16'h0000);
        chk({nm, "_miss_count"}, miss_count, 16'h0000);
`endif
    endtask

    // Reset in the middle of a fill: outputs drop at once, nothing loads
    task automatic reset_mid_fill();
        int idx, tg;
        bit v, wb;
        mon_en = 1'b0;
        idx = $urandom_range(0, 7);
        tg  = 0;
        for (int t = 0; t < 4; t++)
            if (!(mvld[idx][0] && mtag[idx][0] == t) && !(mvld[idx][1] && mtag[idx][1] == t)) tg = t;
        v  = !mvld[idx][0] ? 1'b0 : (!mvld[idx][1] ? 1'b1 : mlru[idx]);
        wb = mvld[idx][v] && mdty[idx][v];
        drive_inputs(idx, tg, 1'b1, 1'b0);
        @(posedge clk); #1;
        if (wb) begin
            chk("rmf_wb_sel", {14'd0, pmem_addr_sel}, v ? 16'd2 : 16'd1);
            pmem_resp = 1'b1;
            @(posedge clk); #1;
            pmem_resp = 1'b0;
        end
        @(posedge clk); #1;
        chk("rmf_in_fill", {14'd0, pmem_read, pmem_write}, 16'b10);
        reset_n = 1'b0;
        #1;
        chk("rmf_outs_in_reset", {7'd0, outs}, 16'd0);
        @(posedge clk); #1;
        mem_read = 1'b0;
        reset_n  = 1'b1;
        for (int i = 0; i < 8; i++) mlru[i] = 1'b0;
        hits   = 0;
        misses = 0;
        expq.delete();
        check_counters("after_reset");
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        index = '0; hit = 1'b0; set_one_hit = 1'b0; set_two_hit = 1'b0;
        set_one_valid = 1'b0; set_two_valid = 1'b0; set_one_dirty = 1'b0; set_two_dirty = 1'b0;
        hits = 0; misses = 0;
        #2;
        // A hitting request during reset must not be answered
        mem_read = 1'b1; hit = 1'b1; set_one_hit = 1'b1; set_one_valid = 1'b1;
        #1;
        chk("reset_outs", {7'd0, outs}, 16'd0);
        check_counters("reset");
        mem_read = 1'b0; hit = 1'b0; set_one_hit = 1'b0; set_one_valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Directed: clean fills, write hit, way-two read hit, dirty way-two writeback
        do_req(3, 1, 0, 1'b0);
        do_req(3, 1, 1, 1'b0);
        do_req(3, 2, 0, 1'b0);
        do_req(3, 2, 0, 1'b0);
        do_req(2, 0, 1, 1'b0);
        do_req(2, 1, 2, 1'b0);
        do_req(2, 0, 0, 1'b0);
        do_req(2, 3, 0, 1'b0);
        do_req(5, 0, 0, 1'b1);
        run_random(150);
        check_counters("mid");

        reset_mid_fill();
        run_random(120);
        @(posedge clk); #1;
        chk("queue_drained", expq.size(), 16'd0);
        check_counters("final");

`ifdef CACHE_PERF_CNT_EN
        // Back-to-back hits past the saturation point
        mon_en = 1'b0;
        index = 3'd0; hit = 1'b1; set_one_hit = 1'b1; set_two_hit = 1'b0;
        set_one_valid = 1'b1; set_one_dirty = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
        repeat (65536) @(posedge clk);
        #1;
        mem_read = 1'b0;
        chk("hit_count_saturated", hit_count, 16'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
